race_sequencer: RTL and testbench

- Sequences the race once the menu FSM enters the game.
- Runs a 3-2-1-GO countdown, then gates player controls into the car datapath.
- Keeps a BCD race clock (m:ss.cc), counts laps from the track finish-line detector and freezes everything on the final lap.
- Sits between the menu FSM outputs (game_visible, controls) and the car motion/overlay logic.

---
 rtl/race_pkg.sv | 45 ++++
 rtl/race_sequencer_bcd_timer.sv | 57 +++++
 rtl/race_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_race_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the race sequencer.
// State encoding, BCD field layout, saturation values, BCD compare helper.
package race_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        RACE      = 2'b11,
        FINISH    = 2'b10
    } state_t;

    localparam int DIGIT_W   = 4;
    localparam int RT_DIGITS = 5;
    localparam int LT_DIGITS = 4;

    localparam int RT_CS1   = 0;
    localparam int RT_CS10  = 4;
    localparam int RT_SEC1  = 8;
    localparam int RT_SEC10 = 12;
    localparam int RT_MIN   = 16;

    localparam logic [RT_DIGITS-1:0] RT_SIX_MASK = 5'b01000;
    localparam logic [LT_DIGITS-1:0] LT_SIX_MASK = 4'b0000;

    localparam logic [19:0] RT_SAT = 20'h95999;
    localparam logic [15:0] LT_SAT = 16'h9999;

    function automatic logic bcd16_less(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic done;
        logic res;
        done = 1'b0;
        res  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!done && a[i*4 +: 4] != b[i*4 +: 4]) begin
                res  = a[i*4 +: 4] < b[i*4 +: 4];
                done = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/race_sequencer_bcd_timer.sv
// Cascaded BCD digit counter with clear, load, increment and saturation.
// Each digit wraps at 9, or at 5 where SIX_MASK marks it.
module bcd_timer
    import race_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter logic [DIGITS-1:0] SIX_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    output logic [DIGITS*DIGIT_W-1:0]   value
);

    logic [DIGITS*DIGIT_W-1:0] nxt;
    logic                      carry;
    logic                      sat;
    logic [DIGIT_W-1:0]        d;
    logic [DIGIT_W-1:0]        dmax;

    // Ripple a +1 through the digits and flag the all-at-max value
    always_comb begin
        nxt   = value;
        carry = 1'b1;
        sat   = 1'b1;
        d     = '0;
        dmax  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d    = value[i*DIGIT_W +: DIGIT_W];
            dmax = SIX_MASK[i] ? 4'd5 : 4'd9;
            if (d != dmax) sat = 1'b0;
            if (carry) begin
                if (d >= dmax) begin
                    nxt[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    nxt[i*DIGIT_W +: DIGIT_W] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Counter register; holds at the saturation value instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc && !sat) begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/race_sequencer.sv
// Race sequencer: 3-2-1-GO countdown, gated controls, BCD race clock, laps.
// Optional best-lap capture enabled by defining RACE_SEQ_BEST_LAP_EN.
module race_sequencer
    import race_pkg::*;
#(
    parameter int TICK_DIV      = 650000,
    parameter int STEP_TICKS    = 100,
    parameter int LAPS          = 3,
    parameter int MIN_LAP_TICKS = 500
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        game_visible,
    input  logic [3:0]  controls_in,
    input  logic        lap_cross,
    output logic [3:0]  controls_out,
    output logic [1:0]  countdown_digit,
    output logic        go_visible,
    output logic [19:0] race_time_bcd,
    output logic [2:0]  lap_count,
    output logic        race_finished,
    output logic [15:0] best_lap_bcd
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam int AW = $clog2(MIN_LAP_TICKS + 1);

    state_t         state;
    logic           gv_q;
    logic [PW-1:0]  pre;
    logic [SW-1:0]  step;
    logic [AW-1:0]  age;
    logic [15:0]    lap_time;

    logic tick, start, abort, go_race, lap_ok, fin_now, enter;
    logic rt_clr, lt_clr, t_inc;

    assign tick    = pre == PW'(TICK_DIV - 1);
    assign start   = game_visible & ~gv_q;
    assign abort   = (state != IDLE) & ~game_visible;
    assign go_race = (state == COUNTDOWN) & tick
                   & (step == SW'(STEP_TICKS - 1))
                   & (countdown_digit == 2'd1);
    assign lap_ok  = (state == RACE) & game_visible & lap_cross
                   & (age >= AW'(MIN_LAP_TICKS));
    assign fin_now = lap_ok & (lap_count == 3'(LAPS - 1));
    assign enter   = abort | ((state == IDLE) & start) | go_race | fin_now;

    assign t_inc  = (state == RACE) & tick & game_visible;
    assign rt_clr = abort | go_race;
    assign lt_clr = abort | go_race | lap_ok;

    bcd_timer #(
        .DIGITS   (RT_DIGITS),
        .SIX_MASK (RT_SIX_MASK)
    ) u_race_time (
        .clk      (pclk),
        .rst      (rst),
        .clr      (rt_clr),
        .inc      (t_inc),
        .load     (1'b0),
        .load_val ('0),
        .value    (race_time_bcd)
    );

    bcd_timer #(
        .DIGITS   (LT_DIGITS),
        .SIX_MASK (LT_SIX_MASK)
    ) u_lap_time (
        .clk      (pclk),
        .rst      (rst),
        .clr      (lt_clr),
        .inc      (t_inc),
        .load     (1'b0),
        .load_val ('0),
        .value    (lap_time)
    );

    // Sequencer FSM with prescaler, step/age counters and registered outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            state           <= IDLE;
            gv_q            <= 1'b0;
            pre             <= '0;
            step            <= '0;
            age             <= '0;
            controls_out    <= '0;
            countdown_digit <= '0;
            go_visible      <= 1'b0;
            lap_count       <= '0;
            race_finished   <= 1'b0;
        end else begin
            gv_q <= game_visible;
            pre  <= (enter || tick) ? '0 : pre + PW'(1);
            if (abort) begin
                state           <= IDLE;
                step            <= '0;
                age             <= '0;
                controls_out    <= '0;
                countdown_digit <= '0;
                go_visible      <= 1'b0;
                lap_count       <= '0;
                race_finished   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        controls_out <= '0;
                        if (start) begin
                            state           <= COUNTDOWN;
                            countdown_digit <= 2'd3;
                            step            <= '0;
                        end
                    end
                    COUNTDOWN: begin
                        controls_out <= '0;
                        if (tick) begin
                            if (step == SW'(STEP_TICKS - 1)) begin
                                step <= '0;
                                if (countdown_digit == 2'd1) begin
                                    state           <= RACE;
                                    countdown_digit <= '0;
                                    go_visible      <= 1'b1;
                                    controls_out    <= controls_in;
                                    age             <= '0;
                                end else begin
                                    countdown_digit <= countdown_digit - 2'd1;
                                end
                            end else begin
                                step <= step + SW'(1);
                            end
                        end
                    end
                    RACE: begin
                        controls_out <= controls_in;
                        if (tick && go_visible) begin
                            if (step == SW'(STEP_TICKS - 1)) begin
                                go_visible <= 1'b0;
                                step       <= '0;
                            end else begin
                                step <= step + SW'(1);
                            end
                        end
                        if (lap_ok) begin
                            lap_count <= lap_count + 3'd1;
                            age       <= '0;
                            if (fin_now) begin
                                state         <= FINISH;
                                race_finished <= 1'b1;
                                controls_out  <= '0;
                            end
                        end else if (tick && age < AW'(MIN_LAP_TICKS)) begin
                            age <= age + AW'(1);
                        end
                    end
                    FINISH: begin
                        controls_out  <= '0;
                        race_finished <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef RACE_SEQ_BEST_LAP_EN
    logic [15:0] best;
    logic        best_vld;

    // Keep the fastest accepted lap; cleared whenever the race is idle
    always_ff @(posedge pclk) begin
        if (rst || abort || state == IDLE) begin
            best     <= '0;
            best_vld <= 1'b0;
        end else if (lap_ok) begin
            if (!best_vld || bcd16_less(lap_time, best)) begin
                best <= lap_time;
            end
            best_vld <= 1'b1;
        end
    end

    assign best_lap_bcd = best;
`else
    assign best_lap_bcd = '0;
`endif

endmodule

// File: tb/tb_race_sequencer.sv
// Self-checking bench for race_sequencer using a timeline-based model.
// Also exercises the BCD timer saturation through a standalone instance.
module tb_race_sequencer;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int NL = 2;
    localparam int ML = 5;
    localparam int CD_LEN = 3 * ST * TD;

    logic        pclk = 1'b0;
    logic        rst;
    logic        game_visible;
    logic [3:0]  controls_in;
    logic        lap_cross;
    logic [3:0]  controls_out;
    logic [1:0]  countdown_digit;
    logic        go_visible;
    logic [19:0] race_time_bcd;
    logic [2:0]  lap_count;
    logic        race_finished;
    logic [15:0] best_lap_bcd;

    logic        sat_rst;
    logic        sat_clr;
    logic        sat_inc;
    logic        sat_load;
    logic [19:0] sat_val;
    logic [19:0] sat_value;

    int checks = 0;
    int errors = 0;

    bit m_act;
    int m_k;
    bit m_gvq;
    int m_laps;
    int m_last;
    bit m_fin;
    int m_freeze;
    int m_best;
    bit m_bvld;

    int len, ab, n, m;
    logic g, rr, l;

    race_sequencer #(
        .TICK_DIV      (TD),
        .STEP_TICKS    (ST),
        .LAPS          (NL),
        .MIN_LAP_TICKS (ML)
    ) dut (
        .pclk            (pclk),
        .rst             (rst),
        .game_visible    (game_visible),
        .controls_in     (controls_in),
        .lap_cross       (lap_cross),
        .controls_out    (controls_out),
        .countdown_digit (countdown_digit),
        .go_visible      (go_visible),
        .race_time_bcd   (race_time_bcd),
        .lap_count       (lap_count),
        .race_finished   (race_finished),
        .best_lap_bcd    (best_lap_bcd)
    );

    bcd_timer #(
        .DIGITS   (5),
        .SIX_MASK (5'b01000)
    ) u_sat (
        .clk      (pclk),
        .rst      (sat_rst),
        .clr      (sat_clr),
        .inc      (sat_inc),
        .load     (sat_load),
        .load_val (sat_val),
        .value    (sat_value)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    // centiseconds -> m:ss.cc BCD, saturating at 9:59.99
    function automatic logic [19:0] bcd5(input int cs);
        int v, s;
        v = cs > 59999 ? 59999 : cs;
        s = (v / 100) % 60;
        return {4'(v / 6000), 4'(s / 10), 4'(s % 10),
                4'((v % 100) / 10), 4'(v % 10)};
    endfunction

    // centiseconds -> ss.cc BCD, saturating at 99.99
    function automatic logic [15:0] bcd4(input int cs);
        int v;
        v = cs > 9999 ? 9999 : cs;
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // race ticks completed after edge k counted from the start edge
    function automatic int t_of(input int k);
        return (k <= CD_LEN) ? 0 : (k - CD_LEN) / TD;
    endfunction

    function automatic bit next_tick();
        return m_act && (m_k + 1 > CD_LEN)
            && ((m_k + 1 - CD_LEN) % TD == 0);
    endfunction

    task automatic m_clear();
        m_act  = 1'b0;
        m_k    = 0;
        m_laps = 0;
        m_last = 0;
        m_fin  = 1'b0;
        m_freeze = 0;
        m_best = 0;
        m_bvld = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic gv,
                              input logic lp);
        int age;
        if (r) begin
            m_clear();
            m_gvq = 1'b0;
        end else begin
            if (m_act && !gv) begin
                m_clear();
            end else if (m_act) begin
                m_k++;
                if (!m_fin && m_k > CD_LEN && lp) begin
                    age = t_of(m_k - 1) - m_last;
                    if (age >= ML) begin
                        m_laps++;
                        if (!m_bvld || age < m_best) m_best = age;
                        m_bvld = 1'b1;
                        m_last = t_of(m_k);
                        if (m_laps == NL) begin
                            m_fin = 1'b1;
                            m_freeze = t_of(m_k);
                        end
                    end
                end
            end else if (gv && !m_gvq) begin
                m_act = 1'b1;
                m_k   = 0;
            end
            m_gvq = gv;
        end
    endtask

    task automatic check_outs(input logic [3:0] ci);
        logic [3:0]  e_ctl;
        logic [1:0]  e_dig;
        logic        e_go;
        logic [19:0] e_time;
        logic [2:0]  e_laps;
        logic        e_fin;
        logic [15:0] e_best;
        int t;
        e_ctl = '0; e_dig = '0; e_go = 1'b0; e_time = '0;
        e_laps = '0; e_fin = 1'b0; e_best = '0;
        if (m_act) begin
            if (m_k < CD_LEN) begin
                e_dig = 2'(3 - m_k / (ST * TD));
            end else if (m_fin) begin
                e_time = bcd5(m_freeze);
                e_laps = 3'(m_laps);
                e_fin  = 1'b1;
            end else begin
                t      = t_of(m_k);
                e_ctl  = ci;
                e_go   = t < ST;
                e_time = bcd5(t);
                e_laps = 3'(m_laps);
            end
`ifdef RACE_SEQ_BEST_LAP_EN
            if (m_bvld) e_best = bcd4(m_best);
`endif
        end
        chk("controls_out", 32'(controls_out), 32'(e_ctl));
        chk("countdown_digit", 32'(countdown_digit), 32'(e_dig));
        chk("go_visible", 32'(go_visible), 32'(e_go));
        chk("race_time_bcd", 32'(race_time_bcd), 32'(e_time));
        chk("lap_count", 32'(lap_count), 32'(e_laps));
        chk("race_finished", 32'(race_finished), 32'(e_fin));
        chk("best_lap_bcd", 32'(best_lap_bcd), 32'(e_best));
    endtask

    task automatic cyc(input logic r, input logic gv,
                       input logic [3:0] c, input logic lp);
        rst          = r;
        game_visible = gv;
        controls_in  = c;
        lap_cross    = lp;
        @(posedge pclk);
        #1;
        model_step(r, gv, lp);
        check_outs(c);
    endtask

    task automatic run_to(input int k, input logic [3:0] c);
        while (m_act && m_k < k - 1) cyc(1'b0, 1'b1, c, 1'b0);
    endtask

    task automatic sat_run(input int start_cs, input int incs);
        sat_val  = bcd5(start_cs);
        sat_load = 1'b1;
        @(posedge pclk);
        #1;
        sat_load = 1'b0;
        sat_inc  = 1'b1;
        repeat (incs) @(posedge pclk);
        #1;
        sat_inc = 1'b0;
        chk("sat_timer", 32'(sat_value), 32'(bcd5(start_cs + incs)));
    endtask

    initial begin
        m_clear();
        m_gvq    = 1'b0;
        sat_rst  = 1'b1;
        sat_clr  = 1'b0;
        sat_inc  = 1'b0;
        sat_load = 1'b0;
        sat_val  = '0;

        repeat (3) cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0);

        // directed race: countdown with all controls held, two laps
        cyc(1'b0, 1'b1, 4'b1111, 1'b0);
        run_to(CD_LEN, 4'b1111);
        cyc(1'b0, 1'b1, 4'b0101, 1'b0);
        run_to(CD_LEN + 3 * TD + 1, 4'b0101);
        cyc(1'b0, 1'b1, 4'b0101, 1'b1);
        run_to(CD_LEN + 6 * TD + 1, 4'b0110);
        cyc(1'b0, 1'b1, 4'b0110, 1'b1);
        run_to(CD_LEN + 13 * TD + 2, 4'b1001);
        cyc(1'b0, 1'b1, 4'b1001, 1'b1);
        repeat (100) cyc(1'b0, 1'b1, 4'($urandom), 1'($urandom));
        cyc(1'b0, 1'b0, 4'b1111, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0);

        // randomized races with aborts and a reset mid-countdown
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(150, 400);
            ab  = (r % 2 == 1) ? $urandom_range(40, len - 5) : -1;
            for (int i = 0; i < len; i++) begin
                g  = !(ab >= 0 && i >= ab && i < ab + 3);
                rr = (r == 2 && i == 20);
                l  = ($urandom_range(0, 7) == 0) && !next_tick();
                cyc(rr, g, 4'($urandom), l);
            end
            repeat (3) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        end

        // race clock saturation and carry chain
        rst          = 1'b0;
        game_visible = 1'b0;
        lap_cross    = 1'b0;
        sat_rst      = 1'b0;
        sat_run(59990, 30);
        sat_run(59999, 10);
        sat_run(959, 41);
        sat_run(5999, 1);
        for (int i = 0; i < 6; i++) begin
            n = (i % 2 == 0) ? $urandom_range(0, 59999)
                             : $urandom_range(59950, 59999);
            m = $urandom_range(0, 60);
            sat_run(n, m);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
